// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared state encoding, default sizes and coordinate type for the fractal scanner
package fractal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int COORD_W_DEF      = 16;
    localparam int DIV_W_DEF        = 8;
    localparam int H_RES_DEF        = 640;
    localparam int V_RES_DEF        = 480;
    localparam int PIPE_LATENCY_DEF = 63;

    typedef logic [COORD_W_DEF-1:0] coord_t;

endpackage

// File: rtl/fractal_delay_line.sv
// rtl/fractal_delay_line.sv - fixed-depth shift register carrying {valid, address} alongside the iteration pipeline
module fractal_delay_line
    import fractal_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = PIPE_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    always_comb begin
        vld_d[0]  = in_valid;
        addr_d[0] = in_addr;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    // Clearing the addresses too keeps wr_addr at 0 after reset, not just wr_en.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/fractal_scan_gen.sv
// rtl/fractal_scan_gen.sv - raster pixel scanner and write-back sequencer; FRACTAL_CONT_EN enables continuous rescan
module fractal_scan_gen
    import fractal_pkg::*;
#(
    parameter int COORD_W      = COORD_W_DEF,
    parameter int DIV_W        = DIV_W_DEF,
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
    parameter int ISSUE_DIV    = 6,
    parameter int ADDR_W       = 19
) (
    input  logic               Clk_100M,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] startX,
    input  logic [COORD_W-1:0] startY,
    input  logic [COORD_W-1:0] stepX,
    input  logic [COORD_W-1:0] stepY,
    output logic               px_valid,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    input  logic [DIV_W-1:0]   div_in,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DIV_W-1:0]   wr_data,
    output logic               busy,
    output logic               frame_done,
    output logic               display
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int COL_W = $clog2(H_RES + 1);
    localparam int CNT_W = $clog2(ISSUE_DIV + 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COORD_W-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
    logic [COORD_W-1:0] start_x_q, start_x_d, step_x_q, step_x_d, step_y_q, step_y_d;
    logic               px_valid_q, px_valid_d;
    logic               busy_q, busy_d, frame_done_q, frame_done_d, display_q, display_d;
    logic               auto_go, accept;

`ifdef FRACTAL_CONT_EN
    // Restart one cycle after frame_done, as if start were pulsed then.
    assign auto_go = (state_q == ST_DONE) && !frame_done_q;
`else
    assign auto_go = 1'b0;
`endif

    assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (start || auto_go);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        start_x_d    = start_x_q;
        step_x_d     = step_x_q;
        step_y_d     = step_y_q;
        px_valid_d   = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        display_d    = display_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    // Pixel (0,0) is issued on the acceptance edge itself.
                    state_d    = (TOTAL == 1) ? ST_DRAIN : ST_SCAN;
                    px_valid_d = 1'b1;
                    px_x_d     = startX;
                    px_y_d     = startY;
                    start_x_d  = startX;
                    step_x_d   = stepX;
                    step_y_d   = stepY;
                    col_d      = '0;
                    cnt_d      = '0;
                    addr_d     = '0;
                    busy_d     = 1'b1;
`ifdef FRACTAL_CONT_EN
                    if (state_q == ST_IDLE) display_d = 1'b0;
`else
                    display_d  = 1'b0;
`endif
                end
            end
            ST_SCAN: begin
                if (cnt_q == CNT_W'(ISSUE_DIV - 1)) begin
                    cnt_d      = '0;
                    px_valid_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    if (col_q == COL_W'(H_RES - 1)) begin
                        col_d  = '0;
                        px_x_d = start_x_q;
                        px_y_d = px_y_q + step_y_q;
                    end else begin
                        col_d  = col_q + COL_W'(1);
                        px_x_d = px_x_q + step_x_q;
                    end
                    if (addr_q == ADDR_W'(TOTAL - 2)) state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (wr_en && (wr_addr == ADDR_W'(TOTAL - 1))) begin
                    state_d      = ST_DONE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    display_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            start_x_q    <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            px_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            display_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            start_x_q    <= start_x_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            px_valid_q   <= px_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            display_q    <= display_d;
        end
    end

    fractal_delay_line #(
        .ADDR_W (ADDR_W),
        .DEPTH  (PIPE_LATENCY)
    ) u_delay (
        .clk       (Clk_100M),
        .clr       (reset),
        .in_valid  (px_valid_q),
        .in_addr   (addr_q),
        .out_valid (wr_en),
        .out_addr  (wr_addr)
    );

    assign px_valid   = px_valid_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign wr_data    = div_in;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign display    = display_q;

endmodule
